// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and constants for muldiv_unit.
// Provides OP_*/ST_* enums, ITERS, DIV0_QUOT and op decode helpers.
package muldiv_pkg;

   localparam int XLEN = 32;
   localparam int ITERS = XLEN;
   localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFFFFFF;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_FIX  = 2'b10
   } state_e;

   function automatic logic op_is_div(op_e o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(op_e o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration (shift-add / restoring).
// Ports: acc, sr, opnd, is_div in; acc_nxt, sr_nxt out.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] sr,
   input  logic [WIDTH-1:0] opnd,
   input  logic             is_div,
   output logic [WIDTH-1:0] acc_nxt,
   output logic [WIDTH-1:0] sr_nxt
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   sh;
   logic             ge;
   logic [WIDTH-1:0] sub;

   always_comb begin
      // Multiply: {acc,sr} shifts right; carry lands in acc MSB.
      sum = {1'b0, acc} + (sr[0] ? {1'b0, opnd} : '0);
      // Divide: remainder shifts left taking next dividend bit.
      sh  = {acc, sr[WIDTH-1]};
      ge  = (sh >= {1'b0, opnd});
      // When ge holds the true difference fits WIDTH bits.
      sub = sh[WIDTH-1:0] - opnd;
      if (is_div) begin
         acc_nxt = ge ? sub : sh[WIDTH-1:0];
         sr_nxt  = {sr[WIDTH-2:0], ge};
      end else begin
         acc_nxt = sum[WIDTH:1];
         sr_nxt  = {sum[0], sr[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO result registers.
// Ports: clk, rst_n, start, op, a, b, flush in; busy, done, hi, lo out.
// Macro MULDIV_FAST_ZERO_EN: zero-operand ops skip straight to FIX.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(ITERS);

   state_e           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] a_raw;
   logic             is_div_r;
   logic             neg_q;
   logic             neg_r;
   logic             div0;

   op_e              op_c;
   logic             op_div;
   logic             op_sgn;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic             fast;

   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] sr_nxt;

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign op_c   = op_e'(op);
   assign op_div = op_is_div(op_c);
   assign op_sgn = op_is_signed(op_c);
   assign abs_a  = (op_sgn && a[WIDTH-1]) ? -a : a;
   assign abs_b  = (op_sgn && b[WIDTH-1]) ? -b : b;

`ifdef MULDIV_FAST_ZERO_EN
   // Any zero operand has a trivial result for both mul and div.
   assign fast = (a == '0) || (b == '0);
`else
   assign fast = 1'b0;
`endif

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc     (acc),
      .sr      (sr),
      .opnd    (opnd),
      .is_div  (is_div_r),
      .acc_nxt (acc_nxt),
      .sr_nxt  (sr_nxt)
   );

   assign prod     = {acc, sr};
   assign prod_fix = neg_q ? -prod : prod;

   always_comb begin
      res_hi = neg_r ? -acc : acc;
      res_lo = neg_q ? -sr : sr;
      unique case (1'b1)
         !is_div_r: {res_hi, res_lo} = prod_fix;
         div0: begin
            res_hi = a_raw;
            res_lo = DIV0_QUOT;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         cnt      <= '0;
         acc      <= '0;
         sr       <= '0;
         opnd     <= '0;
         a_raw    <= '0;
         is_div_r <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div0     <= 1'b0;
      end else if (flush) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  busy     <= 1'b1;
                  cnt      <= '0;
                  acc      <= '0;
                  a_raw    <= a;
                  is_div_r <= op_div;
                  div0     <= op_div && (b == '0);
                  neg_q    <= op_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r    <= op_sgn && a[WIDTH-1];
                  opnd     <= op_div ? abs_b : abs_a;
                  if (fast) begin
                     // Zero {acc,sr} already is the unsigned result.
                     sr    <= '0;
                     state <= ST_FIX;
                  end else begin
                     sr    <= op_div ? abs_a : abs_b;
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               acc <= acc_nxt;
               sr  <= sr_nxt;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(ITERS - 1)) begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               hi    <= res_hi;
               lo    <= res_lo;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
